// File: rtl/key_loader.sv
// Byte-stream key loader: collects KEY_WIDTH/8 key bytes plus an XOR checksum byte,
// and commits a verified key to a held register that drives a logic-locked block.
module key_loader #(
  parameter int KEY_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  input  logic                 s_last,
  input  logic                 key_clear,
  output logic [KEY_WIDTH-1:0] key_out,
  output logic                 key_valid,
  output logic                 done,
  output logic                 err,
  output logic                 busy
);

  localparam int NBYTES = KEY_WIDTH / 8;
  localparam int CW     = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] NB = CW'(NBYTES);

  typedef enum logic [1:0] {RECV, COMMIT, DRAIN} state_t;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          cnt_reg, cnt_next;
  logic [7:0]             acc_reg, acc_next;
  logic [KEY_WIDTH-1:0]   shadow_reg, shadow_next;
  logic                   match_reg, match_next;
  logic [KEY_WIDTH-1:0]   key_reg, key_next;
  logic                   key_valid_reg, key_valid_next;
  logic                   err_reg, err_next;
  logic                   accept;

  assign s_ready   = (state_reg != COMMIT) && !key_clear;
  assign accept    = s_valid && s_ready;
  assign key_out   = key_reg;
  assign key_valid = key_valid_reg;
  assign busy      = (cnt_reg != '0) || (state_reg == COMMIT) || (state_reg == DRAIN);
  // A clear in the COMMIT cycle drops the pending result, so neither pulse may appear.
  assign done = !rst && !key_clear && (state_reg == COMMIT) && match_reg;
  assign err  = !rst && !key_clear && (err_reg || ((state_reg == COMMIT) && !match_reg));

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    acc_next       = acc_reg;
    shadow_next    = shadow_reg;
    match_next     = match_reg;
    key_next       = key_reg;
    key_valid_next = key_valid_reg;
    err_next       = 1'b0;

    if (key_clear) begin
      state_next     = RECV;
      cnt_next       = '0;
      acc_next       = '0;
      key_next       = '0;
      key_valid_next = 1'b0;
    end else begin
      case (state_reg)
        RECV: begin
          if (accept) begin
            if (cnt_reg < NB) begin
              for (int i = 0; i < NBYTES; i++) begin
                if (cnt_reg == CW'(i)) shadow_next[8*i +: 8] = s_data;
              end
              acc_next = acc_reg ^ s_data;
              cnt_next = cnt_reg + CW'(1);
              if (s_last) begin
                err_next = 1'b1;
                cnt_next = '0;
                acc_next = '0;
              end
            end else begin
              cnt_next = '0;
              acc_next = '0;
              if (s_last) begin
                match_next = (s_data == acc_reg);
                state_next = COMMIT;
              end else begin
                err_next   = 1'b1;
                state_next = DRAIN;
              end
            end
          end
        end
        COMMIT: begin
          if (match_reg) begin
            key_next       = shadow_reg;
            key_valid_next = 1'b1;
          end
          state_next = RECV;
        end
        DRAIN: begin
          if (accept && s_last) state_next = RECV;
        end
        default: state_next = RECV;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= RECV;
      cnt_reg       <= '0;
      acc_reg       <= '0;
      shadow_reg    <= '0;
      match_reg     <= 1'b0;
      key_reg       <= '0;
      key_valid_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      acc_reg       <= acc_next;
      shadow_reg    <= shadow_next;
      match_reg     <= match_next;
      key_reg       <= key_next;
      key_valid_reg <= key_valid_next;
      err_reg       <= err_next;
    end
  end

endmodule

// File: tb/tb_key_loader.sv
// Directed testbench for key_loader: framing, checksum, clear and latency scenarios.
module tb_key_loader;

  logic        clk = 1'b0;
  logic        rst, s_valid, s_last, key_clear;
  logic [7:0]  s_data;
  logic        s_ready, key_valid, done, err, busy;
  logic [31:0] key_out;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0, err_cnt = 0, ready_low_cnt = 0;

  key_loader #(.KEY_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .key_clear(key_clear), .key_out(key_out), .key_valid(key_valid),
    .done(done), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (!s_ready) ready_low_cnt++;
      if (done && err) begin
        failures++;
        $display("FAIL done_err_overlap: done=%b err=%b required not both high", done, err);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int waited = 0;
    for (int i = 0; i < gap; i++) @(posedge clk);
    @(negedge clk);
    s_valid = 1'b1; s_data = d; s_last = l;
    while (!s_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (waited >= 20) begin
      failures++;
      $display("FAIL handshake_timeout: s_ready=%b required 1 within 20 cycles", s_ready);
    end
    @(posedge clk); #1;
    $display("byte data=%h last=%b gap=%0d", d, l, gap);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; key_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (key_out !== 32'h0 || key_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: key=%h kv=%b done=%b err=%b rdy=%b busy=%b required 0,0,0,0,1,0",
               key_out, key_valid, done, err, s_ready, busy);
    end
  endtask

  task automatic test_valid_frame;
    int d0 = done_cnt;
    send_byte(8'hEF, 0, 0); send_byte(8'hBE, 0, 0);
    send_byte(8'hAD, 0, 0); send_byte(8'hDE, 0, 0);
    send_byte(8'h22, 1, 0);
    checks++;
    if (done !== 1'b1 || key_out !== 32'h0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL commit_cycle: done=%b key=%h rdy=%b required 1, 00000000, 0", done, key_out, s_ready);
    end
    idle(1);
    checks++;
    if (key_out !== 32'hDEADBEEF || key_valid !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL valid_commit: key=%h kv=%b done=%b required deadbeef,1,0", key_out, key_valid, done);
    end
    idle(2);
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL valid_done_count: got %0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_bad_checksum;
    int e0 = err_cnt, d0 = done_cnt;
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 1);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 2);
    send_byte(8'h00, 1, 0);
    checks++;
    if (err !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL bad_csum_err: err=%b done=%b required 1,0", err, done);
    end
    idle(3);
    checks++;
    if (key_out !== 32'hDEADBEEF || key_valid !== 1'b1 || err_cnt - e0 != 1 || done_cnt - d0 != 0) begin
      failures++;
      $display("FAIL bad_csum_hold: key=%h kv=%b errs=%0d dones=%0d required deadbeef,1,1,0",
               key_out, key_valid, err_cnt - e0, done_cnt - d0);
    end
  endtask

  task automatic test_short_frame;
    int e0 = err_cnt;
    send_byte(8'h11, 0, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL short_busy: busy=%b required 1", busy);
    end
    send_byte(8'h22, 1, 0);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL short_err: err=%b busy=%b required 1,0", err, busy);
    end
    idle(2);
    checks++;
    if (err_cnt - e0 != 1 || key_out !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL short_hold: errs=%0d key=%h required 1,deadbeef", err_cnt - e0, key_out);
    end
    send_byte(8'h01, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h00, 0, 0); send_byte(8'h00, 0, 0);
    send_byte(8'h01, 1, 0);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL short_recover_done: done=%b required 1", done);
    end
    idle(1);
    checks++;
    if (key_out !== 32'h00000001 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL short_recover_key: key=%h kv=%b required 00000001,1", key_out, key_valid);
    end
  endtask

  task automatic test_long_frame;
    int e0 = err_cnt, d0 = done_cnt, r0;
    send_byte(8'h01, 0, 0); send_byte(8'h02, 0, 0);
    send_byte(8'h03, 0, 0); send_byte(8'h04, 0, 0);
    send_byte(8'h04, 0, 0);
    r0 = ready_low_cnt;
    checks++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL long_err: err=%b busy=%b required 1,1", err, busy);
    end
    send_byte(8'h55, 0, 1); send_byte(8'h66, 0, 0); send_byte(8'h77, 1, 2);
    checks++;
    if (ready_low_cnt != r0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL long_drain_ready: ready_low=%0d busy=%b required 0,0", ready_low_cnt - r0, busy);
    end
    idle(3);
    checks++;
    if (err_cnt - e0 != 1 || done_cnt - d0 != 0 || key_out !== 32'h00000001) begin
      failures++;
      $display("FAIL long_hold: errs=%0d dones=%0d key=%h required 1,0,00000001",
               err_cnt - e0, done_cnt - d0, key_out);
    end
    send_byte(8'h10, 0, 0); send_byte(8'h20, 0, 0);
    send_byte(8'h30, 0, 0); send_byte(8'h40, 0, 0);
    send_byte(8'h40, 1, 0);
    idle(1);
    checks++;
    if (key_out !== 32'h40302010 || key_valid !== 1'b1) begin
      failures++;
      $display("FAIL long_recover: key=%h kv=%b required 40302010,1", key_out, key_valid);
    end
  endtask

  task automatic test_clear_in_commit;
    int d0 = done_cnt, e0 = err_cnt;
    send_byte(8'hA1, 0, 0); send_byte(8'hB2, 0, 0);
    send_byte(8'hC3, 0, 0); send_byte(8'hD4, 0, 0);
    send_byte(8'hA1 ^ 8'hB2 ^ 8'hC3 ^ 8'hD4, 1, 0);
    key_clear = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL clear_commit_cycle: rdy=%b done=%b required 0,0", s_ready, done);
    end
    @(posedge clk); #1 key_clear = 1'b0;
    idle(2);
    checks++;
    if (key_out !== 32'h0 || key_valid !== 1'b0 || done_cnt != d0 || err_cnt != e0) begin
      failures++;
      $display("FAIL clear_result: key=%h kv=%b dones=%0d errs=%0d required 0,0,0,0",
               key_out, key_valid, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_gapped_frame;
    int d0 = done_cnt, r0 = ready_low_cnt;
    send_byte(8'hAA, 0, $urandom_range(0, 5)); send_byte(8'h55, 0, $urandom_range(0, 5));
    send_byte(8'hAA, 0, $urandom_range(0, 5)); send_byte(8'h55, 0, $urandom_range(0, 5));
    send_byte(8'h00, 1, $urandom_range(0, 5));
    idle(3);
    checks++;
    if (key_out !== 32'h55AA55AA || key_valid !== 1'b1 || done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL gapped_commit: key=%h kv=%b dones=%0d required 55aa55aa,1,1",
               key_out, key_valid, done_cnt - d0);
    end
    checks++;
    if (ready_low_cnt - r0 != 1) begin
      failures++;
      $display("FAIL gapped_ready: ready_low_cycles=%0d required 1", ready_low_cnt - r0);
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_checksum();
    test_short_frame();
    test_long_frame();
    test_clear_in_commit();
    test_gapped_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
